// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station: holds renamed ops, snoops the CDB, dispatches ready ops to execute.
// Optional second result bus snoop enabled by defining RS_ALU_DUAL_CDB_EN.
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int Q_WIDTH = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,

    input  logic               issue_valid,
    input  logic [9:0]         issue_op,
    input  logic [31:0]        issue_V1,
    input  logic [31:0]        issue_V2,
    input  logic [Q_WIDTH-1:0] issue_Q1,
    input  logic [Q_WIDTH-1:0] issue_Q2,
    input  logic [31:0]        issue_imm,
    input  logic [31:0]        issue_npc,
    input  logic [Q_WIDTH-1:0] issue_dest,
    output logic               full,

    input  logic               cdb_valid,
    input  logic [Q_WIDTH-1:0] cdb_tag,
    input  logic [31:0]        cdb_value,
`ifdef RS_ALU_DUAL_CDB_EN
    input  logic               cdb2_valid,
    input  logic [Q_WIDTH-1:0] cdb2_tag,
    input  logic [31:0]        cdb2_value,
`endif

    output logic               ex_valid,
    output logic [9:0]         ex_op,
    output logic [31:0]        ex_V1,
    output logic [31:0]        ex_V2,
    output logic [31:0]        ex_imm,
    output logic [31:0]        ex_npc,
    output logic [Q_WIDTH-1:0] ex_dest
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [Q_WIDTH-1:0] q1_q   [RS_SIZE];
    logic [Q_WIDTH-1:0] q1_d   [RS_SIZE];
    logic [Q_WIDTH-1:0] q2_q   [RS_SIZE];
    logic [Q_WIDTH-1:0] q2_d   [RS_SIZE];
    logic [9:0]         op_q   [RS_SIZE];
    logic [9:0]         op_d   [RS_SIZE];
    logic [31:0]        v1_q   [RS_SIZE];
    logic [31:0]        v1_d   [RS_SIZE];
    logic [31:0]        v2_q   [RS_SIZE];
    logic [31:0]        v2_d   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        imm_d  [RS_SIZE];
    logic [31:0]        npc_q  [RS_SIZE];
    logic [31:0]        npc_d  [RS_SIZE];
    logic [Q_WIDTH-1:0] dest_q [RS_SIZE];
    logic [Q_WIDTH-1:0] dest_d [RS_SIZE];

    logic               ex_valid_q, ex_valid_d;
    logic [9:0]         ex_op_q, ex_op_d;
    logic [31:0]        ex_v1_q, ex_v1_d;
    logic [31:0]        ex_v2_q, ex_v2_d;
    logic [31:0]        ex_imm_q, ex_imm_d;
    logic [31:0]        ex_npc_q, ex_npc_d;
    logic [Q_WIDTH-1:0] ex_dest_q, ex_dest_d;

    logic [RS_SIZE-1:0] ready;
    logic               free_hit, disp_hit;
    logic [IDX_W-1:0]   free_idx, disp_idx;

    // Tag 0 never matches: it denotes an already-valid operand.
    function automatic logic bus_match(input logic [Q_WIDTH-1:0] q);
        logic hit;
        hit = cdb_valid && (cdb_tag == q);
`ifdef RS_ALU_DUAL_CDB_EN
        hit = hit || (cdb2_valid && (cdb2_tag == q));
`endif
        return (q != '0) && hit;
    endfunction

    function automatic logic [31:0] bus_value(input logic [Q_WIDTH-1:0] q);
`ifdef RS_ALU_DUAL_CDB_EN
        if (!(cdb_valid && (cdb_tag == q))) begin
            return cdb2_value;
        end
`endif
        return cdb_value;
    endfunction

    assign full = ~rdy_in | (&busy_q);

    always_comb begin
        ready    = '0;
        free_hit = 1'b0;
        free_idx = '0;
        disp_hit = 1'b0;
        disp_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            ready[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
            if (!busy_q[i]) begin
                free_hit = 1'b1;
                free_idx = i[IDX_W-1:0];
            end
            if (ready[i]) begin
                disp_hit = 1'b1;
                disp_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        op_d       = op_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        imm_d      = imm_q;
        npc_d      = npc_q;
        dest_d     = dest_q;
        ex_valid_d = 1'b0;
        ex_op_d    = ex_op_q;
        ex_v1_d    = ex_v1_q;
        ex_v2_d    = ex_v2_q;
        ex_imm_d   = ex_imm_q;
        ex_npc_d   = ex_npc_q;
        ex_dest_d  = ex_dest_q;

        if (clear_in) begin
            busy_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && bus_match(q1_q[i])) begin
                    v1_d[i] = bus_value(q1_q[i]);
                    q1_d[i] = '0;
                end
                if (busy_q[i] && bus_match(q2_q[i])) begin
                    v2_d[i] = bus_value(q2_q[i]);
                    q2_d[i] = '0;
                end
            end

            if (disp_hit) begin
                ex_valid_d       = 1'b1;
                ex_op_d          = op_q[disp_idx];
                ex_v1_d          = v1_q[disp_idx];
                ex_v2_d          = v2_q[disp_idx];
                ex_imm_d         = imm_q[disp_idx];
                ex_npc_d         = npc_q[disp_idx];
                ex_dest_d        = dest_q[disp_idx];
                busy_d[disp_idx] = 1'b0;
            end

            // The free slot is always distinct from the dispatching one, since full uses pre-edge state.
            if (issue_valid && free_hit) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = issue_op;
                imm_d[free_idx]  = issue_imm;
                npc_d[free_idx]  = issue_npc;
                dest_d[free_idx] = issue_dest;
                if (bus_match(issue_Q1)) begin
                    v1_d[free_idx] = bus_value(issue_Q1);
                    q1_d[free_idx] = '0;
                end else begin
                    v1_d[free_idx] = issue_V1;
                    q1_d[free_idx] = issue_Q1;
                end
                if (bus_match(issue_Q2)) begin
                    v2_d[free_idx] = bus_value(issue_Q2);
                    q2_d[free_idx] = '0;
                end else begin
                    v2_d[free_idx] = issue_V2;
                    q2_d[free_idx] = issue_Q2;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_v1_q    <= '0;
            ex_v2_q    <= '0;
            ex_imm_q   <= '0;
            ex_npc_q   <= '0;
            ex_dest_q  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                q1_q[i] <= '0;
                q2_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_v1_q    <= ex_v1_d;
            ex_v2_q    <= ex_v2_d;
            ex_imm_q   <= ex_imm_d;
            ex_npc_q   <= ex_npc_d;
            ex_dest_q  <= ex_dest_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
        end
    end

    // Payload fields are only observed while busy, so they need no reset.
    always_ff @(posedge clk_in) begin
        op_q   <= op_d;
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        imm_q  <= imm_d;
        npc_q  <= npc_d;
        dest_q <= dest_d;
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_V1    = ex_v1_q;
    assign ex_V2    = ex_v2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_npc   = ex_npc_q;
    assign ex_dest  = ex_dest_q;

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - randomized self-checking bench for rs_alu against a behavioural entry-pool model.
module tb_rs_alu;

    localparam int RS = 8;
    localparam int QW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, clear_in;
    logic          issue_valid;
    logic [9:0]    issue_op;
    logic [31:0]   issue_V1, issue_V2, issue_imm, issue_npc;
    logic [QW-1:0] issue_Q1, issue_Q2, issue_dest;
    logic          full;
    logic          cdb_valid;
    logic [QW-1:0] cdb_tag;
    logic [31:0]   cdb_value;
`ifdef RS_ALU_DUAL_CDB_EN
    logic          cdb2_valid;
    logic [QW-1:0] cdb2_tag;
    logic [31:0]   cdb2_value;
`endif
    logic          ex_valid;
    logic [9:0]    ex_op;
    logic [31:0]   ex_V1, ex_V2, ex_imm, ex_npc;
    logic [QW-1:0] ex_dest;

    always #5 clk_in = ~clk_in;

    rs_alu #(.RS_SIZE(RS), .Q_WIDTH(QW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_V1(issue_V1), .issue_V2(issue_V2),
        .issue_Q1(issue_Q1), .issue_Q2(issue_Q2), .issue_imm(issue_imm), .issue_npc(issue_npc),
        .issue_dest(issue_dest), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
`ifdef RS_ALU_DUAL_CDB_EN
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
`endif
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_V1(ex_V1), .ex_V2(ex_V2),
        .ex_imm(ex_imm), .ex_npc(ex_npc), .ex_dest(ex_dest)
    );

    typedef struct {
        bit            busy;
        logic [9:0]    op;
        logic [31:0]   v1, v2, imm, npc;
        logic [QW-1:0] q1, q2, dest;
    } ent_t;

    ent_t          m [RS];
    bit            mx_valid;
    logic [9:0]    mx_op;
    logic [31:0]   mx_v1, mx_v2, mx_imm, mx_npc;
    logic [QW-1:0] mx_dest;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_full();
        bit all_busy = 1;
        for (int i = 0; i < RS; i++) all_busy &= m[i].busy;
        return !rdy_in || all_busy;
    endfunction

    // A tag resolves if a bus carries it this cycle; the primary bus wins on a collision.
    function automatic bit resolve(input logic [QW-1:0] q, output logic [31:0] v);
        v = 32'h0;
        if (q == 0) return 0;
        if (cdb_valid && cdb_tag == q) begin
            v = cdb_value;
            return 1;
        end
`ifdef RS_ALU_DUAL_CDB_EN
        if (cdb2_valid && cdb2_tag == q) begin
            v = cdb2_value;
            return 1;
        end
`endif
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < RS; i++) m[i].busy = 0;
        mx_valid = 0; mx_op = 0; mx_v1 = 0; mx_v2 = 0; mx_imm = 0; mx_npc = 0; mx_dest = 0;
    endtask

    task automatic model_edge();
        ent_t        n [RS];
        bit          was_full;
        logic [31:0] v;
        n        = m;
        was_full = m_full();
        mx_valid = 0;
        if (clear_in) begin
            for (int i = 0; i < RS; i++) n[i].busy = 0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS; i++) begin
                if (m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) begin
                    mx_valid = 1; mx_op = m[i].op; mx_v1 = m[i].v1; mx_v2 = m[i].v2;
                    mx_imm = m[i].imm; mx_npc = m[i].npc; mx_dest = m[i].dest;
                    n[i].busy = 0;
                    break;
                end
            end
            for (int i = 0; i < RS; i++) begin
                if (m[i].busy && resolve(m[i].q1, v)) begin n[i].v1 = v; n[i].q1 = 0; end
                if (m[i].busy && resolve(m[i].q2, v)) begin n[i].v2 = v; n[i].q2 = 0; end
            end
            if (issue_valid && !was_full) begin
                for (int i = 0; i < RS; i++) begin
                    if (!m[i].busy) begin
                        n[i].busy = 1; n[i].op = issue_op; n[i].imm = issue_imm;
                        n[i].npc = issue_npc; n[i].dest = issue_dest;
                        n[i].v1 = issue_V1; n[i].q1 = issue_Q1;
                        n[i].v2 = issue_V2; n[i].q2 = issue_Q2;
                        if (resolve(issue_Q1, v)) begin n[i].v1 = v; n[i].q1 = 0; end
                        if (resolve(issue_Q2, v)) begin n[i].v2 = v; n[i].q2 = 0; end
                        break;
                    end
                end
            end
        end
        m = n;
    endtask

    task automatic check_outputs();
        chk("ex_valid", ex_valid, mx_valid);
        chk("ex_op", ex_op, mx_op);
        chk("ex_V1", ex_V1, mx_v1);
        chk("ex_V2", ex_V2, mx_v2);
        chk("ex_imm", ex_imm, mx_imm);
        chk("ex_npc", ex_npc, mx_npc);
        chk("ex_dest", ex_dest, mx_dest);
    endtask

    task automatic idle();
        rdy_in = 1; clear_in = 0; issue_valid = 0; issue_op = 0;
        issue_V1 = 0; issue_V2 = 0; issue_Q1 = 0; issue_Q2 = 0;
        issue_imm = 0; issue_npc = 0; issue_dest = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
`ifdef RS_ALU_DUAL_CDB_EN
        cdb2_valid = 0; cdb2_tag = 0; cdb2_value = 0;
`endif
    endtask

    task automatic issue(input logic [9:0] op, input logic [31:0] v1, input logic [QW-1:0] q1,
                         input logic [31:0] v2, input logic [QW-1:0] q2, input logic [QW-1:0] dest);
        issue_valid = 1; issue_op = op; issue_V1 = v1; issue_Q1 = q1;
        issue_V2 = v2; issue_Q2 = q2; issue_dest = dest;
        issue_imm = 32'h1000 + dest; issue_npc = 32'h8000_0000 + dest;
    endtask

    task automatic bcast(input logic [QW-1:0] tag, input logic [31:0] val);
        cdb_valid = 1; cdb_tag = tag; cdb_value = val;
    endtask

    // Called about 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle();
        #1 chk("full", full, m_full());
        @(posedge clk_in);
        model_edge();
        #1 check_outputs();
    endtask

    initial begin
        idle();
        rst_in = 0;
        m_reset();
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1;
        check_outputs();
        chk("reset_full", full, 0);

        // Ready ADD dispatches one cycle after issue.
        issue(10'h080, 5, 0, 7, 0, 3); cycle();
        idle(); cycle();
        chk("add_valid", ex_valid, 1); chk("add_v1", ex_V1, 5);
        chk("add_v2", ex_V2, 7); chk("add_dest", ex_dest, 3);
        cycle();
        chk("add_drop", ex_valid, 0);

        // Wakeup via later broadcast.
        issue(10'h081, 0, 4, 9, 0, 7); cycle();
        idle(); cycle();
        bcast(4, 32'h10); cycle();
        chk("wake_wait", ex_valid, 0);
        idle(); cycle();
        chk("wake_valid", ex_valid, 1); chk("wake_v1", ex_V1, 32'h10);

        // Bypass in the issue cycle.
        issue(10'h082, 1, 0, 0, 6, 8); bcast(6, 32'hAB); cycle();
        idle(); cycle();
        chk("byp_valid", ex_valid, 1); chk("byp_v2", ex_V2, 32'hAB);

        // Fill all slots, reject the ninth, then drain in index order.
        idle();
        for (int i = 0; i < RS; i++) begin
            issue(10'h090, i, 9, 0, 0, QW'(i + 10)); cycle();
        end
        chk("fill_full", full, 1);
        issue(10'h091, 0, 0, 0, 0, 31); cycle();
        idle(); bcast(9, 32'h55); cycle();
        idle();
        for (int i = 0; i < RS; i++) begin
            cycle();
            chk("drain_dest", ex_dest, i + 10);
            chk("drain_v1", ex_V1, 32'h55);
            if (i == 0) chk("drain_full", full, 0);
        end
        cycle();
        chk("drain_empty", ex_valid, 0);

        // Flush discards waiting entries.
        for (int i = 0; i < 3; i++) begin
            issue(10'h0A0, 0, 20, 0, 0, QW'(i + 1)); cycle();
        end
        idle(); clear_in = 1; cycle();
        idle(); chk("clr_full", full, 0);
        bcast(20, 32'h77); cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("clr_nodisp", ex_valid, 0);
        end

        // Asynchronous reset between edges.
        issue(10'h0B0, 1, 0, 2, 0, 12); cycle();
        issue(10'h0B1, 3, 0, 4, 0, 13); cycle();
        idle();
        chk("pre_rst_valid", ex_valid, 1);
        #2 rst_in = 0;
        m_reset();
        #1 chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_dest", ex_dest, 0);
        @(negedge clk_in);
        rst_in = 1;
        @(posedge clk_in); #1;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("post_rst_nodisp", ex_valid, 0);
        end

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) != 0) begin
                issue(10'($urandom), $urandom, QW'($urandom_range(0, 6)),
                      $urandom, QW'($urandom_range(0, 6)), QW'($urandom));
                issue_imm = $urandom; issue_npc = $urandom;
            end
            if (rdy_in && $urandom_range(0, 1) != 0)
                bcast(QW'($urandom_range(0, 6)), $urandom);
`ifdef RS_ALU_DUAL_CDB_EN
            if (rdy_in && $urandom_range(0, 2) == 0) begin
                cdb2_valid = 1; cdb2_tag = QW'($urandom_range(0, 6)); cdb2_value = $urandom;
            end
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
